// File: rtl/cpu_dmem_arbiter.sv
// cpu_dmem_arbiter: round-robin share of the 16-bit dmem bus between
// port 0 (execute stores/pushes) and port 1 (memory loads/pops).
// 32-bit accesses are split into two big-endian 16-bit beats.
// Build option: DMEM_ARB_MISALIGN_TRAP_EN -- when defined, a short/long access
// with adr[0]=1 is rejected with an error and no bus cycle; when undefined,
// adr[0] is cleared for short/long and the access proceeds.
//
// state | meaning
// IDLE  | bus idle, arbitrate pending requests
// BEAT0 | first (or only) beat on the bus
// BEAT1 | second beat of a long access, address adr+2
// RESP  | one-cycle ack/err to the granted port, bus idle
module cpu_dmem_arbiter #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req0_we_i,
  input  logic [1:0]  req0_size_i,
  input  logic [31:0] req0_adr_i,
  input  logic [31:0] req0_dat_i,
  output logic [31:0] req0_dat_o,
  output logic        req0_ack_o,
  output logic        req0_err_o,
  input  logic        req1_i,
  input  logic        req1_we_i,
  input  logic [1:0]  req1_size_i,
  input  logic [31:0] req1_adr_i,
  input  logic [31:0] req1_dat_i,
  output logic [31:0] req1_dat_o,
  output logic        req1_ack_o,
  output logic        req1_err_o,
  output logic        dmem_cyc_o,
  output logic        dmem_stb_o,
  output logic        dmem_we_o,
  output logic [1:0]  dmem_sel_o,
  output logic [31:0] dmem_address_o,
  output logic [15:0] dmem_data_o,
  input  logic [15:0] dmem_data_i,
  input  logic        dmem_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(ACK_TIMEOUT);

  state_t      r_state, w_state_nxt;
  logic        r_last_grant, w_last_grant_nxt;
  logic        r_port, w_port_nxt;
  logic [1:0]  r_size, w_size_nxt;
  logic [31:0] r_adr, w_adr_nxt;
  logic [31:0] r_wdat, w_wdat_nxt;
  logic [15:0] r_rdat_hi, w_rdat_hi_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_cyc, w_cyc_nxt;
  logic        r_stb, w_stb_nxt;
  logic        r_we, w_we_nxt;
  logic [1:0]  r_bsel, w_bsel_nxt;
  logic [31:0] r_badr, w_badr_nxt;
  logic [15:0] r_bdat, w_bdat_nxt;
  logic [31:0] r_dat0, w_dat0_nxt;
  logic [31:0] r_dat1, w_dat1_nxt;
  logic        r_ack0, w_ack0_nxt;
  logic        r_ack1, w_ack1_nxt;
  logic        r_err0, w_err0_nxt;
  logic        r_err1, w_err1_nxt;

  logic        w_req_any;
  logic        w_grant_port;
  logic        w_sel_we;
  logic [1:0]  w_sel_size;
  logic [31:0] w_sel_adr;
  logic [31:0] w_sel_dat;
  logic [31:0] w_adr_lat;
  logic [7:0]  w_cnt_inc;
  logic [31:0] w_rd_word;
  logic        w_done;
  logic        w_fail;

  // Round-robin pick: contested grant goes to the port that was not served last.
  assign w_req_any    = req0_i | req1_i;
  assign w_grant_port = (req0_i & req1_i) ? ~r_last_grant : req1_i;
  assign w_sel_we     = w_grant_port ? req1_we_i   : req0_we_i;
  assign w_sel_size   = w_grant_port ? req1_size_i : req0_size_i;
  assign w_sel_adr    = w_grant_port ? req1_adr_i  : req0_adr_i;
  assign w_sel_dat    = w_grant_port ? req1_dat_i  : req0_dat_i;
  assign w_adr_lat    = (w_sel_size == 2'b00) ? w_sel_adr : {w_sel_adr[31:1], 1'b0};
  assign w_cnt_inc    = r_cnt + 8'd1;

  // Read data assembly for the beat completing this cycle.
  always_comb begin
    w_rd_word = {r_rdat_hi, dmem_data_i};
    if (r_size == 2'b00)
      w_rd_word = {24'b0, (r_adr[0] ? dmem_data_i[7:0] : dmem_data_i[15:8])};
    else if (r_size == 2'b01)
      w_rd_word = {16'b0, dmem_data_i};
  end

  // Next-state, next-bus and response logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_port_nxt       = r_port;
    w_size_nxt       = r_size;
    w_adr_nxt        = r_adr;
    w_wdat_nxt       = r_wdat;
    w_rdat_hi_nxt    = r_rdat_hi;
    w_cnt_nxt        = r_cnt;
    w_cyc_nxt        = r_cyc;
    w_stb_nxt        = r_stb;
    w_we_nxt         = r_we;
    w_bsel_nxt       = r_bsel;
    w_badr_nxt       = r_badr;
    w_bdat_nxt       = r_bdat;
    w_dat0_nxt       = r_dat0;
    w_dat1_nxt       = r_dat1;
    w_ack0_nxt       = 1'b0;
    w_ack1_nxt       = 1'b0;
    w_err0_nxt       = 1'b0;
    w_err1_nxt       = 1'b0;
    w_done           = 1'b0;
    w_fail           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_last_grant_nxt = w_grant_port;
          w_port_nxt       = w_grant_port;
          w_size_nxt       = w_sel_size;
          w_adr_nxt        = w_adr_lat;
          w_wdat_nxt       = w_sel_dat;
          w_cnt_nxt        = 8'd0;
          w_state_nxt      = S_BEAT0;
          w_cyc_nxt        = 1'b1;
          w_stb_nxt        = 1'b1;
          w_we_nxt         = w_sel_we;
          w_badr_nxt       = w_adr_lat;
          if (w_sel_size == 2'b00) begin
            w_bsel_nxt = w_sel_adr[0] ? 2'b01 : 2'b10;
            w_bdat_nxt = {w_sel_dat[7:0], w_sel_dat[7:0]};
          end else if (w_sel_size == 2'b01) begin
            w_bsel_nxt = 2'b11;
            w_bdat_nxt = w_sel_dat[15:0];
          end else begin
            w_bsel_nxt = 2'b11;
            w_bdat_nxt = w_sel_dat[31:16];
          end
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
          if ((w_sel_size != 2'b00) && w_sel_adr[0])
            w_fail = 1'b1;
`endif
        end
      end
      S_BEAT0, S_BEAT1: begin
        if (dmem_ack_i) begin
          if ((r_state == S_BEAT0) && r_size[1]) begin
            w_state_nxt   = S_BEAT1;
            w_rdat_hi_nxt = dmem_data_i;
            w_badr_nxt    = r_adr + 32'd2;
            w_bdat_nxt    = r_wdat[15:0];
            w_cnt_nxt     = 8'd0;
          end else begin
            w_done = 1'b1;
          end
        end else if (w_cnt_inc == LP_TIMEOUT) begin
          w_fail = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_done | w_fail) begin
      w_state_nxt = S_RESP;
      w_cyc_nxt   = 1'b0;
      w_stb_nxt   = 1'b0;
      w_we_nxt    = 1'b0;
      w_bsel_nxt  = 2'b00;
    end
    if (w_done) begin
      if (w_port_nxt) begin
        w_ack1_nxt = 1'b1;
        if (!r_we) w_dat1_nxt = w_rd_word;
      end else begin
        w_ack0_nxt = 1'b1;
        if (!r_we) w_dat0_nxt = w_rd_word;
      end
    end
    if (w_fail) begin
      if (w_port_nxt) w_err1_nxt = 1'b1;
      else            w_err0_nxt = 1'b1;
    end
  end

  // State and registered outputs; reset drops the bus immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_size       <= 2'b00;
      r_adr        <= 32'd0;
      r_wdat       <= 32'd0;
      r_rdat_hi    <= 16'd0;
      r_cnt        <= 8'd0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_bsel       <= 2'b00;
      r_badr       <= 32'd0;
      r_bdat       <= 16'd0;
      r_dat0       <= 32'd0;
      r_dat1       <= 32'd0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_port       <= w_port_nxt;
      r_size       <= w_size_nxt;
      r_adr        <= w_adr_nxt;
      r_wdat       <= w_wdat_nxt;
      r_rdat_hi    <= w_rdat_hi_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cyc        <= w_cyc_nxt;
      r_stb        <= w_stb_nxt;
      r_we         <= w_we_nxt;
      r_bsel       <= w_bsel_nxt;
      r_badr       <= w_badr_nxt;
      r_bdat       <= w_bdat_nxt;
      r_dat0       <= w_dat0_nxt;
      r_dat1       <= w_dat1_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_err0       <= w_err0_nxt;
      r_err1       <= w_err1_nxt;
    end
  end

  assign dmem_cyc_o     = r_cyc;
  assign dmem_stb_o     = r_stb;
  assign dmem_we_o      = r_we;
  assign dmem_sel_o     = r_bsel;
  assign dmem_address_o = r_badr;
  assign dmem_data_o    = r_bdat;
  assign req0_dat_o     = r_dat0;
  assign req0_ack_o     = r_ack0;
  assign req0_err_o     = r_err0;
  assign req1_dat_o     = r_dat1;
  assign req1_ack_o     = r_ack1;
  assign req1_err_o     = r_err1;

endmodule

// File: tb/tb_cpu_dmem_arbiter.sv
// Directed bench for cpu_dmem_arbiter with a bus responder and two
// scoreboards: expected bus beats and expected port responses.
module tb_cpu_dmem_arbiter;

  typedef struct packed {
    logic [31:0] adr;
    logic [1:0]  sel;
    logic        we;
    logic [15:0] wdat;
    logic [15:0] rdat;
    logic [7:0]  lat;   // 0 = never acknowledge
  } beat_t;

  typedef struct packed {
    logic        port;
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } resp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_i, req0_we_i, req1_i, req1_we_i;
  logic [1:0]  req0_size_i, req1_size_i;
  logic [31:0] req0_adr_i, req0_dat_i, req1_adr_i, req1_dat_i;
  logic [31:0] req0_dat_o, req1_dat_o;
  logic        req0_ack_o, req0_err_o, req1_ack_o, req1_err_o;
  logic        dmem_cyc_o, dmem_stb_o, dmem_we_o;
  logic [1:0]  dmem_sel_o;
  logic [31:0] dmem_address_o;
  logic [15:0] dmem_data_o;
  logic [15:0] dmem_data_i = 16'd0;
  logic        dmem_ack_i  = 1'b0;

  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;
  int wait_cnt = 0;
  int cc;
  int base;
  logic found;
  beat_t beat_q[$];
  resp_t resp_q[$];
  beat_t b;
  resp_t e;

  cpu_dmem_arbiter #(.ACK_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .req0_we_i(req0_we_i), .req0_size_i(req0_size_i),
    .req0_adr_i(req0_adr_i), .req0_dat_i(req0_dat_i), .req0_dat_o(req0_dat_o),
    .req0_ack_o(req0_ack_o), .req0_err_o(req0_err_o),
    .req1_i(req1_i), .req1_we_i(req1_we_i), .req1_size_i(req1_size_i),
    .req1_adr_i(req1_adr_i), .req1_dat_i(req1_dat_i), .req1_dat_o(req1_dat_o),
    .req1_ack_o(req1_ack_o), .req1_err_o(req1_err_o),
    .dmem_cyc_o(dmem_cyc_o), .dmem_stb_o(dmem_stb_o), .dmem_we_o(dmem_we_o),
    .dmem_sel_o(dmem_sel_o), .dmem_address_o(dmem_address_o),
    .dmem_data_o(dmem_data_o), .dmem_data_i(dmem_data_i), .dmem_ack_i(dmem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] adr, input logic [1:0] sel, input logic we,
                           input logic [15:0] wdat, input logic [15:0] rdat, input logic [7:0] lat);
    beat_t nb;
    nb.adr = adr; nb.sel = sel; nb.we = we; nb.wdat = wdat; nb.rdat = rdat; nb.lat = lat;
    beat_q.push_back(nb);
  endtask

  task automatic push_resp(input logic port, input logic err, input logic chk, input logic [31:0] dat);
    resp_t nr;
    nr.port = port; nr.err = err; nr.chk = chk; nr.dat = dat;
    resp_q.push_back(nr);
  endtask

  task automatic drive0(input logic we, input logic [1:0] size, input logic [31:0] adr, input logic [31:0] dat);
    req0_we_i = we; req0_size_i = size; req0_adr_i = adr; req0_dat_i = dat; req0_i = 1'b1;
  endtask

  task automatic drive1(input logic we, input logic [1:0] size, input logic [31:0] adr, input logic [31:0] dat);
    req1_we_i = we; req1_size_i = size; req1_adr_i = adr; req1_dat_i = dat; req1_i = 1'b1;
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  // Wait for n responses within a cycle budget, counting cycles with cyc high.
  task automatic run(input string tag, input int n_resp, output int cyc_cycles);
    int start;
    start = resp_cnt;
    cyc_cycles = 0;
    for (int i = 0; i < 100 && (resp_cnt - start) < n_resp; i++) begin
      step();
      if (dmem_cyc_o) cyc_cycles++;
    end
    check({tag, "_resp_count"}, resp_cnt - start, n_resp);
    req0_i = 1'b0;
    req1_i = 1'b0;
  endtask

  task automatic handle_resp(input logic port, input logic ack, input logic err, input logic [31:0] dat);
    resp_cnt++;
    check("resp_bus_idle", {31'b0, dmem_cyc_o}, 32'd0);
    checks++;
    assert (resp_q.size() != 0) else begin
      failures++;
      $error("FAIL resp_unexpected port=%0d ack=%0d err=%0d expected=none", port, ack, err);
    end
    if (resp_q.size() != 0) begin
      e = resp_q.pop_front();
      check("resp_port", {31'b0, port}, {31'b0, e.port});
      check("resp_ack_err", {30'b0, ack, err}, {30'b0, ~e.err, e.err});
      if (e.chk) check("resp_data", dat, e.dat);
    end
  endtask

  // Response monitor.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1) begin
      if (req0_ack_o | req0_err_o) handle_resp(1'b0, req0_ack_o, req0_err_o, req0_dat_o);
      if (req1_ack_o | req1_err_o) handle_resp(1'b1, req1_ack_o, req1_err_o, req1_dat_o);
    end
  end

  // Bus responder: acknowledges each expected beat after its latency.
  always @(negedge clk_i) begin
    dmem_ack_i = 1'b0;
    if (rst_i === 1'b1 && dmem_cyc_o && dmem_stb_o) begin
      wait_cnt++;
      if (beat_q.size() == 0) begin
        if (wait_cnt == 1) begin
          checks++;
          failures++;
          $error("FAIL bus_unexpected_beat adr=%h expected=none", dmem_address_o);
        end
      end else begin
        b = beat_q[0];
        if (b.lat != 8'd0 && wait_cnt == int'(b.lat)) begin
          check("beat_adr", dmem_address_o, b.adr);
          check("beat_sel", {30'b0, dmem_sel_o}, {30'b0, b.sel});
          check("beat_we", {31'b0, dmem_we_o}, {31'b0, b.we});
          if (b.we) check("beat_wdat", {16'b0, dmem_data_o}, {16'b0, b.wdat});
          dmem_data_i = b.rdat;
          dmem_ack_i = 1'b1;
          void'(beat_q.pop_front());
          wait_cnt = 0;
        end
      end
    end else begin
      wait_cnt = 0;
    end
  end

  initial begin
    rst_i = 1'b0;
    req0_i = 1'b0; req0_we_i = 1'b0; req0_size_i = 2'b00; req0_adr_i = '0; req0_dat_i = '0;
    req1_i = 1'b0; req1_we_i = 1'b0; req1_size_i = 2'b00; req1_adr_i = '0; req1_dat_i = '0;
    repeat (3) step();
    check("reset_ctl", {23'b0, dmem_cyc_o, dmem_stb_o, dmem_we_o, dmem_sel_o,
                        req0_ack_o, req0_err_o, req1_ack_o, req1_err_o}, 32'd0);
    check("reset_adr", dmem_address_o, 32'd0);
    check("reset_dat", req0_dat_o | req1_dat_o | {16'b0, dmem_data_o}, 32'd0);
    rst_i = 1'b1;
    step();

    // Port 0 byte write at odd address.
    push_beat(32'h0000_1001, 2'b01, 1'b1, 16'hA5A5, 16'h0, 8'd1);
    push_resp(1'b0, 1'b0, 1'b0, 32'h0);
    drive0(1'b1, 2'b00, 32'h0000_1001, 32'h0000_00A5);
    run("byte_wr", 1, cc);
    check("byte_wr_cyc_cycles", cc, 1);
    step();

    // Port 1 long read, big-endian assembly.
    push_beat(32'h0000_2000, 2'b11, 1'b0, 16'h0, 16'h1234, 8'd1);
    push_beat(32'h0000_2002, 2'b11, 1'b0, 16'h0, 16'h5678, 8'd1);
    push_resp(1'b1, 1'b0, 1'b1, 32'h1234_5678);
    drive1(1'b0, 2'b10, 32'h0000_2000, 32'h0);
    run("long_rd", 1, cc);
    check("long_rd_cyc_cycles", cc, 2);
    step();

    // Byte reads: even address uses upper lane, odd uses lower lane.
    push_beat(32'h0000_3000, 2'b10, 1'b0, 16'h0, 16'hC37E, 8'd2);
    push_resp(1'b0, 1'b0, 1'b1, 32'h0000_00C3);
    drive0(1'b0, 2'b00, 32'h0000_3000, 32'h0);
    run("byte_rd_even", 1, cc);
    step();
    push_beat(32'h0000_3001, 2'b01, 1'b0, 16'h0, 16'hC37E, 8'd1);
    push_resp(1'b1, 1'b0, 1'b1, 32'h0000_007E);
    drive1(1'b0, 2'b00, 32'h0000_3001, 32'h0);
    run("byte_rd_odd", 1, cc);
    step();

    // Both long writes together: port 0 then port 1.
    push_beat(32'h0000_4000, 2'b11, 1'b1, 16'hDEAD, 16'h0, 8'd1);
    push_beat(32'h0000_4002, 2'b11, 1'b1, 16'hBEEF, 16'h0, 8'd1);
    push_resp(1'b0, 1'b0, 1'b0, 32'h0);
    push_beat(32'h0000_5000, 2'b11, 1'b1, 16'hCAFE, 16'h0, 8'd1);
    push_beat(32'h0000_5002, 2'b11, 1'b1, 16'hF00D, 16'h0, 8'd1);
    push_resp(1'b1, 1'b0, 1'b0, 32'h0);
    drive0(1'b1, 2'b10, 32'h0000_4000, 32'hDEAD_BEEF);
    drive1(1'b1, 2'b10, 32'h0000_5000, 32'hCAFE_F00D);
    run("rr_pair", 2, cc);
    step();

    // Both held: grants alternate 0,1,0.
    for (int k = 0; k < 3; k++) begin
      if (k % 2 == 0) begin
        push_beat(32'h0000_4000, 2'b11, 1'b1, 16'hDEAD, 16'h0, 8'd1);
        push_beat(32'h0000_4002, 2'b11, 1'b1, 16'hBEEF, 16'h0, 8'd1);
        push_resp(1'b0, 1'b0, 1'b0, 32'h0);
      end else begin
        push_beat(32'h0000_5000, 2'b11, 1'b1, 16'hCAFE, 16'h0, 8'd1);
        push_beat(32'h0000_5002, 2'b11, 1'b1, 16'hF00D, 16'h0, 8'd1);
        push_resp(1'b1, 1'b0, 1'b0, 32'h0);
      end
    end
    drive0(1'b1, 2'b10, 32'h0000_4000, 32'hDEAD_BEEF);
    drive1(1'b1, 2'b10, 32'h0000_5000, 32'hCAFE_F00D);
    run("rr_held", 3, cc);
    step();

    // Short write, then long write wrapping the 32-bit address.
    push_beat(32'h0000_6000, 2'b11, 1'b1, 16'h1357, 16'h0, 8'd3);
    push_resp(1'b1, 1'b0, 1'b0, 32'h0);
    drive1(1'b1, 2'b01, 32'h0000_6000, 32'h0000_1357);
    run("short_wr", 1, cc);
    step();
    push_beat(32'hFFFF_FFFE, 2'b11, 1'b1, 16'h0102, 16'h0, 8'd1);
    push_beat(32'h0000_0000, 2'b11, 1'b1, 16'h0304, 16'h0, 8'd1);
    push_resp(1'b0, 1'b0, 1'b0, 32'h0);
    drive0(1'b1, 2'b10, 32'hFFFF_FFFE, 32'h0102_0304);
    run("wrap_wr", 1, cc);
    step();

    // Timeout: no ack in BEAT0, bus drops after 4 cycles with err.
    push_beat(32'h0000_7000, 2'b11, 1'b1, 16'hAABB, 16'h0, 8'd0);
    push_resp(1'b0, 1'b1, 1'b0, 32'h0);
    drive0(1'b1, 2'b10, 32'h0000_7000, 32'hAABB_CCDD);
    run("timeout", 1, cc);
    check("timeout_cyc_cycles", cc, 4);
    check("timeout_beat_left", beat_q.size(), 1);
    beat_q.delete();
    step();

    // Misaligned short read.
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    push_resp(1'b1, 1'b1, 1'b0, 32'h0);
    drive1(1'b0, 2'b01, 32'h0000_0003, 32'h0);
    run("misalign", 1, cc);
    check("misalign_cyc_cycles", cc, 0);
`else
    push_beat(32'h0000_0002, 2'b11, 1'b0, 16'h0, 16'hBEEF, 8'd1);
    push_resp(1'b1, 1'b0, 1'b1, 32'h0000_BEEF);
    drive1(1'b0, 2'b01, 32'h0000_0003, 32'h0);
    run("misalign", 1, cc);
    check("misalign_cyc_cycles", cc, 1);
`endif
    step();

    // Reset during BEAT1 of a long read.
    push_beat(32'h0000_8000, 2'b11, 1'b0, 16'h0, 16'h1111, 8'd1);
    push_beat(32'h0000_8002, 2'b11, 1'b0, 16'h0, 16'h2222, 8'd0);
    drive1(1'b0, 2'b10, 32'h0000_8000, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (dmem_cyc_o && dmem_address_o == 32'h0000_8002) found = 1'b1;
    end
    check("rst_beat1_reached", {31'b0, found}, 32'd1);
    #1;
    base = resp_cnt;
    rst_i = 1'b0;
    #1;
    check("rst_async_bus", {30'b0, dmem_cyc_o, dmem_stb_o}, 32'd0);
    req1_i = 1'b0;
    beat_q.delete();
    step();
    rst_i = 1'b1;
    repeat (3) step();
    check("rst_no_resp", resp_cnt - base, 0);

    // After reset the first contested grant goes to port 0.
    push_beat(32'h0000_9000, 2'b11, 1'b1, 16'hAAAA, 16'h0, 8'd1);
    push_resp(1'b0, 1'b0, 1'b0, 32'h0);
    push_beat(32'h0000_9100, 2'b11, 1'b1, 16'hBBBB, 16'h0, 8'd1);
    push_resp(1'b1, 1'b0, 1'b0, 32'h0);
    drive1(1'b1, 2'b01, 32'h0000_9100, 32'h0000_BBBB);
    drive0(1'b1, 2'b01, 32'h0000_9000, 32'h0000_AAAA);
    run("post_rst", 2, cc);
    repeat (3) step();

    check("beat_q_empty", beat_q.size(), 0);
    check("resp_q_empty", resp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
